// File: rtl/spi_flash_responder.sv
// spi_flash_responder
// SPI mode-0 target that behaves like a small configuration flash. SCK, CSn
// and MOSI are oversampled in the 48 MHz domain. The block decodes the flash
// command set and serves reads and page programs from a byte-wide memory port.
//
// Ports
//   clk_48mhz    sole clock
//   resetn       asynchronous active-low reset
//   spi_sck      SPI clock in (asynchronous, at most clk_48mhz/8)
//   spi_csn      chip select in, active low (asynchronous)
//   spi_mosi     serial data in, MSB first
//   spi_miso     serial data out, MSB first, changes after SCK falls
//   spi_miso_oe  drive enable for spi_miso
//   mem_addr     memory byte address
//   mem_rd_en    one-cycle read strobe; mem_rdata is valid on the next cycle
//   mem_rdata    memory read data
//   mem_wr_en    one-cycle write strobe
//   mem_wdata    write data, valid with mem_wr_en
//   wel          write-enable latch (for LED/debug)
module spi_flash_responder #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk_48mhz,
    input  logic              resetn,
    input  logic              spi_sck,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    output logic              wel
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, RESP, DATA_RD, DATA_WR, IGNORE
    } state_t;

    state_t state, state_next;

    logic sck_meta, sck_s, sck_prev;
    logic csn_meta, csn_s;
    logic mosi_meta, mosi_s;

    logic [4:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic [22:0] addr_shift;
    logic [23:0] addr_full;
    logic [7:0]  tx_shift;
    logic        miso_reg;
    logic [1:0]  resp_idx;
    logic        is_read;
    logic        wr_armed;
    logic        rd_pending;
    logic [7:0]  status_byte;

    logic sck_rise, sck_fall, byte_done, addr_done;

    // Two-FF synchronizers. sck_prev is the third stage that is used for
    // edge detection. CSn resets high so the bus starts out deselected.
    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            sck_meta  <= 1'b0;
            sck_s     <= 1'b0;
            sck_prev  <= 1'b0;
            csn_meta  <= 1'b1;
            csn_s     <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            sck_meta  <= spi_sck;
            sck_s     <= sck_meta;
            sck_prev  <= sck_s;
            csn_meta  <= spi_csn;
            csn_s     <= csn_meta;
            mosi_meta <= spi_mosi;
            mosi_s    <= mosi_meta;
        end
    end

    // A deselected bus masks SCK edges, so a CSn rise always beats a
    // coincident edge.
    assign sck_rise    = sck_s & ~sck_prev & ~csn_s;
    assign sck_fall    = ~sck_s & sck_prev & ~csn_s;
    assign rx_byte     = {rx_shift, mosi_s};
    assign addr_full   = {addr_shift, mosi_s};
    assign byte_done   = sck_rise && (bit_cnt == 5'd7);
    assign addr_done   = sck_rise && (bit_cnt == 5'd23) && (state == ADDR);
    assign status_byte = {6'b0, wel, 1'b0};

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (csn_s) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = CMD;
                CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            8'h05, 8'h9F: state_next = RESP;
                            8'h03:        state_next = ADDR;
                            8'h02:        state_next = wel ? ADDR : IGNORE;
                            default:      state_next = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (addr_done) begin
                        state_next = is_read ? DATA_RD : DATA_WR;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        spi_miso_oe = ((state == RESP) || (state == DATA_RD)) && !csn_s;
        spi_miso    = spi_miso_oe ? miso_reg : 1'b0;
    end

    // The TX byte for the next slot is loaded on the rising edge that
    // completes the current byte. Falls then shift it out MSB first, so the
    // first bit is already on the line when the next byte begins. Read data
    // is loaded two cycles after its strobe, which is well before the next
    // fall because SCK runs no faster than clk/8.
    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_wdata  <= 8'h00;
            wel        <= 1'b0;
            bit_cnt    <= 5'd0;
            rx_shift   <= 7'd0;
            addr_shift <= 23'd0;
            tx_shift   <= 8'h00;
            miso_reg   <= 1'b0;
            resp_idx   <= 2'd0;
            is_read    <= 1'b0;
            wr_armed   <= 1'b0;
            rd_pending <= 1'b0;
        end else begin
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            rd_pending <= mem_rd_en;

            // Page-program addresses wrap within the 256-byte page.
            if (mem_wr_en) begin
                mem_addr[7:0] <= mem_addr[7:0] + 8'd1;
            end

            if (csn_s) begin
                bit_cnt    <= 5'd0;
                rx_shift   <= 7'd0;
                tx_shift   <= 8'h00;
                miso_reg   <= 1'b0;
                resp_idx   <= 2'd0;
                rd_pending <= 1'b0;
                wr_armed   <= 1'b0;
                if (wr_armed) begin
                    wel <= 1'b0;
                end
            end else begin
                if (state_next != state) begin
                    bit_cnt <= 5'd0;
                end else if (sck_rise) begin
                    bit_cnt <= (byte_done && state != ADDR) ? 5'd0 : bit_cnt + 5'd1;
                end

                if (sck_rise) begin
                    rx_shift <= rx_byte[6:0];
                end

                if (rd_pending) begin
                    tx_shift <= mem_rdata;
                end else if (sck_fall) begin
                    miso_reg <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end

                case (state)
                    CMD: begin
                        if (byte_done) begin
                            case (rx_byte)
                                8'h06: wel <= 1'b1;
                                8'h04: wel <= 1'b0;
                                8'h05: begin
                                    tx_shift <= status_byte;
                                    resp_idx <= 2'd0;
                                end
                                8'h9F: begin
                                    tx_shift <= JEDEC_ID[23:16];
                                    resp_idx <= 2'd1;
                                end
                                8'h03: is_read <= 1'b1;
                                8'h02: is_read <= 1'b0;
                                default: ;
                            endcase
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            addr_shift <= addr_full[22:0];
                        end
                        if (addr_done) begin
                            mem_addr  <= addr_full[ADDR_W-1:0];
                            mem_rd_en <= is_read;
                            if (!is_read) begin
                                wr_armed <= 1'b1;
                            end
                        end
                    end
                    // resp_idx 0 means repeating status. Values 1..3 step
                    // through the remaining JEDEC bytes and then repeat 0x00.
                    RESP: begin
                        if (byte_done) begin
                            case (resp_idx)
                                2'd0: tx_shift <= status_byte;
                                2'd1: begin
                                    tx_shift <= JEDEC_ID[15:8];
                                    resp_idx <= 2'd2;
                                end
                                2'd2: begin
                                    tx_shift <= JEDEC_ID[7:0];
                                    resp_idx <= 2'd3;
                                end
                                default: tx_shift <= 8'h00;
                            endcase
                        end
                    end
                    DATA_RD: begin
                        if (byte_done) begin
                            mem_addr  <= mem_addr + ADDR_W'(1);
                            mem_rd_en <= 1'b1;
                        end
                    end
                    DATA_WR: begin
                        if (byte_done) begin
                            mem_wdata <= rx_byte;
                            mem_wr_en <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed testbench for spi_flash_responder. A small byte memory model
// answers reads, and write/read strobes are logged into queues for checking.
// SPI pins change at 5 ns past a clock edge, so they never coincide with
// clk_48mhz edges.
module tb_spi_flash_responder;

    logic        clk_48mhz = 1'b0;
    logic        resetn    = 1'b0;
    logic        spi_sck   = 1'b0;
    logic        spi_csn   = 1'b1;
    logic        spi_mosi  = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [23:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_wr_en;
    logic [7:0]  mem_wdata;
    logic        wel;

    int check_count = 0;
    int pass_count  = 0;

    logic [7:0]  mem_model [0:511];
    logic [23:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic [23:0] rd_addr_q [$];

    spi_flash_responder #(.ADDR_W(24), .JEDEC_ID(24'hEF4016)) dut (
        .clk_48mhz  (clk_48mhz),
        .resetn     (resetn),
        .spi_sck    (spi_sck),
        .spi_csn    (spi_csn),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .wel        (wel)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    // The memory model and strobe log sample on the falling edge. The read
    // data is therefore stable across the next rising edge and the one after.
    always @(negedge clk_48mhz) begin
        if (mem_rd_en) begin
            mem_rdata = mem_model[mem_addr[8:0]];
            rd_addr_q.push_back(mem_addr);
        end
        if (mem_wr_en) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Shift nbits of tx (MSB first) in mode 0 at 6 MHz. MISO is sampled just
    // before each rising edge.
    task automatic applyStimulus(input logic [7:0] tx, input int nbits,
                                 output logic [7:0] rx, output logic oe_any,
                                 output logic oe_all);
        rx     = 8'h00;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            #80;
            rx      = {rx[6:0], spi_miso};
            oe_any |= spi_miso_oe;
            oe_all &= spi_miso_oe;
            spi_sck = 1'b1;
            #80;
            spi_sck = 1'b0;
        end
    endtask

    task automatic csLow();
        spi_csn = 1'b0;
        #200;
    endtask

    task automatic csHigh();
        #80;
        spi_csn = 1'b1;
        #200;
    endtask

    task automatic sendBytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input int n);
        logic [7:0] rx;
        logic       a, b;
        logic [7:0] seq [4];
        seq = '{b0, b1, b2, b3};
        for (int i = 0; i < n; i++) applyStimulus(seq[i], 8, rx, a, b);
    endtask

    task automatic sendCmd(input logic [7:0] op);
        csLow();
        sendBytes(op, 8'h00, 8'h00, 8'h00, 1);
        csHigh();
    endtask

    task automatic readStatus(output logic [7:0] status);
        logic a, b;
        csLow();
        sendBytes(8'h05, 8'h00, 8'h00, 8'h00, 1);
        applyStimulus(8'h00, 8, status, a, b);
        csHigh();
    endtask

    logic [7:0] rx;
    logic       oe_any, oe_all;
    logic [7:0] jedec_exp [4];
    logic [7:0] rd_exp [4];
    logic [23:0] rd_addr_exp [4];

    initial begin
        for (int i = 0; i < 512; i++) mem_model[i] = 8'(i);
        jedec_exp   = '{8'hEF, 8'h40, 8'h16, 8'h00};
        rd_exp      = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        rd_addr_exp = '{24'h0000FE, 24'h0000FF, 24'h000100, 24'h000101};

        #105;
        checkOutput("rst_miso", 32'(spi_miso), 0);
        checkOutput("rst_oe", 32'(spi_miso_oe), 0);
        checkOutput("rst_rd_en", 32'(mem_rd_en), 0);
        checkOutput("rst_wr_en", 32'(mem_wr_en), 0);
        checkOutput("rst_addr", 32'(mem_addr), 0);
        checkOutput("rst_wdata", 32'(mem_wdata), 0);
        checkOutput("rst_wel", 32'(wel), 0);
        resetn = 1'b1;
        #200;

        // JEDEC ID
        csLow();
        applyStimulus(8'h9F, 8, rx, oe_any, oe_all);
        checkOutput("jedec_cmd_oe", 32'(oe_any), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 8, rx, oe_any, oe_all);
            checkOutput($sformatf("jedec_byte%0d", i), 32'(rx), 32'(jedec_exp[i]));
            checkOutput($sformatf("jedec_oe%0d", i), 32'(oe_all), 1);
        end
        csHigh();
        checkOutput("jedec_oe_idle", 32'(spi_miso_oe), 0);

        // Status and write-enable latch
        readStatus(rx);
        checkOutput("status_init", 32'(rx), 32'h00);
        sendCmd(8'h06);
        checkOutput("wel_set", 32'(wel), 1);
        readStatus(rx);
        checkOutput("status_wel", 32'(rx), 32'h02);
        sendCmd(8'h04);
        checkOutput("wel_clr", 32'(wel), 0);
        readStatus(rx);
        checkOutput("status_wrdi", 32'(rx), 32'h00);

        // Read across the 0xFF/0x100 boundary
        rd_addr_q.delete();
        csLow();
        sendBytes(8'h03, 8'h00, 8'h00, 8'hFE, 4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 8, rx, oe_any, oe_all);
            checkOutput($sformatf("read_byte%0d", i), 32'(rx), 32'(rd_exp[i]));
        end
        csHigh();
        checkOutput("read_strobes", rd_addr_q.size(), 5);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("read_addr%0d", i),
                        (i < rd_addr_q.size()) ? 32'(rd_addr_q[i]) : 32'hDEAD,
                        32'(rd_addr_exp[i]));
        end

        // Page program with page wrap
        sendCmd(8'h06);
        wr_addr_q.delete();
        wr_data_q.delete();
        csLow();
        sendBytes(8'h02, 8'h00, 8'h00, 8'hFE, 4);
        sendBytes(8'hAA, 8'hBB, 8'hCC, 8'h00, 3);
        csHigh();
        checkOutput("pp_count", wr_addr_q.size(), 3);
        if (wr_addr_q.size() == 3) begin
            checkOutput("pp_addr0", 32'(wr_addr_q[0]), 32'h0000FE);
            checkOutput("pp_data0", 32'(wr_data_q[0]), 32'hAA);
            checkOutput("pp_addr1", 32'(wr_addr_q[1]), 32'h0000FF);
            checkOutput("pp_data1", 32'(wr_data_q[1]), 32'hBB);
            checkOutput("pp_addr2", 32'(wr_addr_q[2]), 32'h000000);
            checkOutput("pp_data2", 32'(wr_data_q[2]), 32'hCC);
        end
        readStatus(rx);
        checkOutput("pp_status_after", 32'(rx), 32'h00);

        // Page program without WEL is ignored
        wr_addr_q.delete();
        csLow();
        sendBytes(8'h02, 8'h00, 8'h00, 8'h20, 4);
        sendBytes(8'h11, 8'h22, 8'h00, 8'h00, 2);
        csHigh();
        checkOutput("pp_nowel_count", wr_addr_q.size(), 0);

        // One full byte then a partial byte cut by CSn
        sendCmd(8'h06);
        wr_addr_q.delete();
        wr_data_q.delete();
        csLow();
        sendBytes(8'h02, 8'h00, 8'h00, 8'h10, 4);
        sendBytes(8'h5A, 8'h00, 8'h00, 8'h00, 1);
        applyStimulus(8'hF0, 4, rx, oe_any, oe_all);
        csHigh();
        checkOutput("partial_count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            checkOutput("partial_addr", 32'(wr_addr_q[0]), 32'h10);
            checkOutput("partial_data", 32'(wr_data_q[0]), 32'h5A);
        end
        checkOutput("partial_wel", 32'(wel), 0);

        // Reset asserted mid-byte during a page program
        sendCmd(8'h06);
        wr_addr_q.delete();
        rd_addr_q.delete();
        csLow();
        sendBytes(8'h02, 8'h00, 8'h00, 8'h20, 4);
        applyStimulus(8'h3C, 4, rx, oe_any, oe_all);
        #40;
        resetn = 1'b0;
        #1;
        checkOutput("abort_addr", 32'(mem_addr), 0);
        checkOutput("abort_wdata", 32'(mem_wdata), 0);
        checkOutput("abort_wel", 32'(wel), 0);
        checkOutput("abort_wr_en", 32'(mem_wr_en), 0);
        checkOutput("abort_oe", 32'(spi_miso_oe), 0);
        #100;
        spi_csn = 1'b1;
        #100;
        resetn = 1'b1;
        #200;
        checkOutput("abort_no_write", wr_addr_q.size(), 0);
        checkOutput("abort_no_read", rd_addr_q.size(), 0);
        readStatus(rx);
        checkOutput("abort_status", 32'(rx), 32'h00);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
